// File: rtl/spi_master_tx_if.sv
// Request/handshake side and SPI pin side of the frame transmitter.
// The requester (master) drives start and the frame fields. The transmitter (slave) drives the pins and status.
interface spi_master_tx_if;
  localparam int unsigned CMD_W  = 8;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  logic              start;
  logic [CMD_W-1:0]  cmd;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              sck;
  logic              cs;
  logic              mosi;
  logic              busy;
  logic              done;

  modport master (output start, cmd, address, data, input sck, cs, mosi, busy, done);
  modport slave  (input start, cmd, address, data, output sck, cs, mosi, busy, done);
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmitter: sends one {cmd, address, data} frame MSB first per accepted start.
// sck, cs setup, cs hold and the deselect gap are all derived from one CLK_DIV-cycle divider.
module spi_master_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_master_tx_if.slave bus
);
  localparam int unsigned TC_W  = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = 7;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [TC_W-1:0]      tc_q, tc_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic                 sck_q, sck_d;
  logic                 cs_q, cs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick_c;

  assign tick_c = (tc_q == TC_W'(CLK_DIV - 1));

  // mosi is the shift register MSB; it reaches zero once all bits have been shifted out
  assign bus.sck  = sck_q;
  assign bus.cs   = cs_q;
  assign bus.mosi = sr_q[FRAME_LEN-1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tc_q     <= '0;
      bitcnt_q <= '0;
      sr_q     <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tc_d     = tick_c ? '0 : tc_q + TC_W'(1);
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tc_d  = '0;
        sck_d = 1'b0;
        if (bus.start) begin
          sr_d     = FRAME_LEN'({bus.cmd, bus.address, bus.data});
          bitcnt_d = '0;
          cs_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (tick_c) begin
          sck_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (sck_q) begin
            // falling edge: present the next bit
            sck_d = 1'b0;
            sr_d  = {sr_q[FRAME_LEN-2:0], 1'b0};
            if (bitcnt_q < BIT_W'(FRAME_LEN)) bitcnt_d = bitcnt_q + BIT_W'(1);
          end else if (bitcnt_q == BIT_W'(FRAME_LEN)) begin
            // last low phase finished: no further rising edge
            state_d = HOLD;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: table-driven and random frames against a cycle-indexed waveform model.
module tb_spi_master_tx;
  localparam int D     = 4;
  localparam int NBITS = 64;
  localparam int LAST  = 131 * D + 1;

  logic clk;
  logic rst_n;

  spi_master_tx_if bus();

  spi_master_tx #(.CLK_DIV(D), .FRAME_LEN(NBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] address;
    logic [31:0] data;
    logic [63:0] frame;
    bit          disturb;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected {cs, sck, mosi, busy, done} k cycles after the accepting edge
  function automatic logic [4:0] model(input int k, input logic [63:0] f);
    int   p;
    int   idx;
    logic cs_e, sck_e, mosi_e, busy_e, done_e;
    busy_e = (k >= 1) && (k <= 131 * D);
    cs_e   = !((k >= 1) && (k <= 130 * D));
    done_e = (k == 130 * D + 1);
    p      = k - 1 - D;
    sck_e  = (p >= 0) && (p < 2 * NBITS * D) && (((p / D) % 2) == 0);
    idx    = (k - 1) / (2 * D);
    mosi_e = (k >= 1) && (idx < NBITS) ? f[NBITS-1-idx] : 1'b0;
    return {cs_e, sck_e, mosi_e, busy_e, done_e};
  endfunction

  // Caller is positioned at a negedge; start is accepted at the following posedge
  task automatic run_frame(input string name, input logic [7:0] c, input logic [23:0] a,
                           input logic [31:0] d, input logic [63:0] exp, input bit disturb,
                           input bit hold, input int rst_at, output int cs_tail);
    logic [63:0] bits;
    logic [4:0]  act;
    logic [4:0]  want;
    logic        prev_sck;
    int rises, dones, bad, first_bad, t_cs, t_rise, t_done, t_busy;
    bits = '0; prev_sck = 1'b0;
    rises = 0; dones = 0; bad = 0; first_bad = -1;
    t_cs = -1; t_rise = -1; t_done = -1; t_busy = -1;
    cs_tail = 0;
    bus.cmd = c; bus.address = a; bus.data = d; bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= LAST; k++) begin
      @(negedge clk);
      if (!hold) bus.start = disturb && (k == 10 || k == 520 || k == 521 || k == 523);
      if (disturb && k == 2) begin
        bus.cmd = 8'($urandom); bus.address = 24'($urandom); bus.data = $urandom;
      end
      if (k == rst_at) begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check({name, " rst cs"},   64'(bus.cs),   64'(1));
        check({name, " rst sck"},  64'(bus.sck),  64'(0));
        check({name, " rst mosi"}, 64'(bus.mosi), 64'(0));
        check({name, " rst busy"}, 64'(bus.busy), 64'(0));
        check({name, " rst done"}, 64'(bus.done), 64'(0));
        check({name, " prior wave"}, 64'(bad), 64'(0));
        check({name, " no done"},  64'(dones), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      act  = {bus.cs, bus.sck, bus.mosi, bus.busy, bus.done};
      want = model(k, exp);
      if (act !== want) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (!prev_sck && bus.sck) begin
        rises++;
        bits = {bits[62:0], bus.mosi};
        if (t_rise < 0) t_rise = k;
      end
      prev_sck = bus.sck;
      if (bus.done) begin
        dones++;
        if (t_done < 0) t_done = k;
      end
      if (!bus.cs && t_cs < 0) t_cs = k;
      if (!bus.busy && t_busy < 0) t_busy = k;
      cs_tail = bus.cs ? cs_tail + 1 : 0;
    end
    check({name, " bits"},       bits,           exp);
    check({name, " rises"},      64'(rises),     64'(NBITS));
    check({name, " done count"}, 64'(dones),     64'(1));
    check({name, " cs fall"},    64'(t_cs),      64'(1));
    check({name, " first rise"}, 64'(t_rise),    64'(1 + D));
    check({name, " done cycle"}, 64'(t_done),    64'(130 * D + 1));
    check({name, " busy fall"},  64'(t_busy),    64'(131 * D + 1));
    check({name, " wave mismatches"}, 64'(bad),  64'(0));
    if (bad != 0) $display("  %s first differing cycle %0d", name, first_bad);
  endtask

  vec_t tbl[5];
  int   tail;
  int   tail1;

  initial begin
    tbl[0] = '{8'hB5, 24'h123456, 32'hDEADBEEF, 64'hB5123456DEADBEEF, 1'b0};
    tbl[1] = '{8'hB5, 24'h123456, 32'hDEADBEEF, 64'hB5123456DEADBEEF, 1'b1};
    tbl[2] = '{8'hFF, 24'hFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[3] = '{8'h80, 24'h000001, 32'h80000001, 64'h8000000180000001, 1'b0};
    tbl[4] = '{8'h00, 24'hA5A5A5, 32'h0000005A, 64'h00A5A5A50000005A, 1'b1};

    rst_n = 1'b1;
    bus.start = 1'b0; bus.cmd = '0; bus.address = '0; bus.data = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset cs",   64'(bus.cs),   64'(1));
    check("reset sck",  64'(bus.sck),  64'(0));
    check("reset mosi", 64'(bus.mosi), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_frame($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].address, tbl[i].data,
                tbl[i].frame, tbl[i].disturb, 1'b0, -1, tail);

    for (int i = 0; i < 3; i++) begin
      logic [7:0]  rc;
      logic [23:0] ra;
      logic [31:0] rd;
      rc = 8'($urandom); ra = 24'($urandom); rd = $urandom;
      run_frame($sformatf("rand%0d", i), rc, ra, rd, {rc, ra, rd}, 1'($urandom), 1'b0, -1, tail);
    end

    // start held high: two back-to-back frames separated by the deselect gap
    run_frame("hold0", 8'h01, 24'h0, 32'h0, 64'h0100000000000000, 1'b0, 1'b1, -1, tail1);
    run_frame("hold1", 8'h01, 24'h0, 32'h0, 64'h0100000000000000, 1'b0, 1'b1, -1, tail);
    bus.start = 1'b0;
    check("hold gap >= CLK_DIV", 64'(tail1 >= D), 64'(1));

    // mid-frame reset, then a clean frame
    run_frame("midrst", 8'hB5, 24'h123456, 32'hDEADBEEF, 64'hB5123456DEADBEEF, 1'b0, 1'b0, 200, tail);
    check("post-reset idle cs",   64'(bus.cs),   64'(1));
    check("post-reset idle busy", 64'(bus.busy), 64'(0));
    run_frame("after_rst", 8'h3C, 24'hC0FFEE, 32'h12345678, 64'h3CC0FFEE12345678, 1'b0, 1'b0, -1, tail);

    for (int k = 0; k < 2 * D; k++) begin
      @(negedge clk);
      check("idle tail cs",   64'(bus.cs),   64'(1));
      check("idle tail done", 64'(bus.done), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
